sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch path (icache refill reads) and the data path (loads/stores).
- Sits between the icache/EX-stage sram interfaces and the single external memory port.
- One transaction outstanding at a time.
- Data has priority, with a bounded-starvation rule for instruction fetch.
- Supports cancellation of an in-flight fetch on branch redirect.

Parameters:
- MAX_DATA_STREAK, 2: max consecutive data grants while inst_req is pending; the next grant then goes to inst.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch read request.
- inst_addr  in  32  fetch address.
- inst_cancel  in  1  branch redirect; drop the pending/in-flight fetch.
- inst_addr_ok  out  1  fetch request accepted (1-cycle pulse).
- inst_data_ok  out  1  fetch data valid (1-cycle pulse).
- inst_rdata  out  32  fetch data.
- data_req  in  1  data request.
- data_we  in  1  1 = store, 0 = load.
- data_wstrb  in  4  byte strobes for a store.
- data_addr  in  32  data address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data request accepted (pulse).
- data_data_ok  out  1  load data valid / store done (pulse).
- data_rdata  out  32  load data.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_wstrb  out  4  memory byte strobes; 0 for reads.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_addr_ok  in  1  memory accepted the address.
- mem_data_ok  in  1  memory response valid.
- mem_rdata  in  32  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (sync, high):
  - state = IDLE, streak counter = 0, owner = data, drop flag = 0.
  - All outputs 0, including rdata and the mem_* fields.
  - Reset mid-transaction abandons it silently; the memory model shares the same reset.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If any qualified request is present, grant it.
  - In the same cycle, pulse the owner's addr_ok and latch owner, we, wstrb, addr, wdata into registers.
  - Next state is REQ.
  - inst qualified = inst_req & ~inst_cancel; a cancel in the same cycle wins and the fetch is not accepted.
  - Reads drive mem_wstrb = 0.
- Grant rule:
  - Only data qualified: grant data.
  - Only inst qualified: grant inst.
  - Both qualified: grant inst if streak == MAX_DATA_STREAK, else grant data.
- Streak counter:
  - +1 on a data grant while inst_req is high.
  - Cleared on an inst grant, or in any IDLE cycle with inst_req low.
  - Saturates at MAX_DATA_STREAK.
  - Width is clog2(MAX_DATA_STREAK+1).
- REQ:
  - mem_req = 1 with all mem_* fields driven from the latched registers and held stable until mem_addr_ok.
  - On mem_addr_ok, drop mem_req next cycle and go to RESP.
  - A mem_data_ok arriving in REQ is a protocol violation and is ignored.
- RESP:
  - mem_req = 0; wait for mem_data_ok.
  - On mem_data_ok:
    - Register mem_rdata into the owner's rdata.
    - Pulse the owner's data_ok in the next cycle, unless the drop flag is set.
    - Go to IDLE.
  - The non-owner's rdata is unchanged.
- Latency, with zero-wait memory:
  - accept in cycle t, mem_req in t+1, mem_addr_ok in t+1, mem_data_ok in t+2, data_ok in t+3.
  - A new accept can occur in t+3 (IDLE).
- Cancel:
  - inst_cancel while owner = inst and state is REQ or RESP sets the drop flag.
  - The memory transaction still completes, with mem_req held until addr_ok, but inst_data_ok is suppressed.
  - The drop flag clears on entering IDLE.
  - inst_cancel has no effect in the cycle inst_data_ok is already high, or when owner = data.
- addr_ok and data_ok pulses are exactly 1 cycle. inst and data pulses are never both high in the same cycle.
- Requesters hold req/fields until addr_ok; the arbiter does not sample them after accept.

Test Plan:
- Reset asserted mid-RESP of a load:
  - Next cycle busy = 0 and all outputs 0.
  - A late mem_data_ok pulse produces no data_data_ok.
- Single load, addr 0x1c000100, zero-wait memory returning 0xdeadbeef:
  - data_addr_ok at t, mem_req at t+1 with wstrb 0.
  - data_data_ok at t+3 with data_rdata = 0xdeadbeef.
- Store, wstrb 4'b0011, wdata 0x12345678, mem_addr_ok delayed 3 cycles:
  - mem_req/addr/wdata/wstrb stay stable for all 3 cycles.
  - data_data_ok fires exactly once.
- inst_req and data_req held continuously, MAX_DATA_STREAK = 2:
  - Grant order is data, data, inst, data, data, inst.
- Fetch in RESP, inst_cancel pulsed:
  - mem_data_ok arrives, no inst_data_ok.
  - A pending data request is accepted in the following IDLE cycle.
- inst_req and inst_cancel high together in IDLE with no data_req:
  - No accept, busy stays 0, inst_addr_ok = 0.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like memory port between instruction fetch
// and the load/store path. One transaction outstanding; data wins ties unless
// fetch has been passed over MAX_DATA_STREAK times in a row. A branch
// redirect can drop an in-flight fetch without disturbing the memory side.
module sram_arbiter #(
  parameter int MAX_DATA_STREAK = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int SW = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic OWN_DATA = 1'b0;
  localparam logic OWN_INST = 1'b1;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          owner_q, owner_d;
  logic          drop_q, drop_d;
  logic          we_q, we_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   inst_rdata_q, inst_rdata_d;
  logic [31:0]   data_rdata_q, data_rdata_d;
  logic          inst_dok_q, inst_dok_d;
  logic          data_dok_q, data_dok_d;

  logic inst_qual;
  logic grant_inst;
  logic grant_data;

  // Grant decision: only in IDLE; a same-cycle cancel disqualifies the fetch.
  always_comb begin
    inst_qual  = inst_req & ~inst_cancel;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (state_q == S_IDLE && !reset) begin
      if (data_req && inst_qual) begin
        if (streak_q == STREAK_MAX) grant_inst = 1'b1;
        else                        grant_data = 1'b1;
      end else if (data_req) begin
        grant_data = 1'b1;
      end else if (inst_qual) begin
        grant_inst = 1'b1;
      end
    end
  end

  // Next-state logic: latch the granted request, track the memory handshake,
  // and turn the memory response into a one-cycle data_ok for the owner.
  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    owner_d      = owner_q;
    drop_d       = drop_q;
    we_d         = we_q;
    wstrb_d      = wstrb_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_dok_d   = 1'b0;
    data_dok_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        // Streak only counts data wins that actually made fetch wait.
        if (!inst_req || grant_inst) begin
          streak_d = '0;
        end else if (grant_data && streak_q != STREAK_MAX) begin
          streak_d = streak_q + SW'(1);
        end
        if (grant_inst) begin
          owner_d = OWN_INST;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
          addr_d  = inst_addr;
          wdata_d = 32'h0;
          state_d = S_REQ;
        end else if (grant_data) begin
          owner_d = OWN_DATA;
          we_d    = data_we;
          wstrb_d = data_we ? data_wstrb : 4'b0000;
          addr_d  = data_addr;
          wdata_d = data_wdata;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (inst_cancel && owner_q == OWN_INST) drop_d = 1'b1;
        // A stray mem_data_ok here is ignored.
        if (mem_addr_ok) state_d = S_RESP;
      end
      S_RESP: begin
        if (inst_cancel && owner_q == OWN_INST) drop_d = 1'b1;
        if (mem_data_ok) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
          if (owner_q == OWN_INST) begin
            inst_rdata_d = mem_rdata;
            // A cancel landing with the response still suppresses it.
            inst_dok_d   = ~drop_q & ~inst_cancel;
          end else begin
            data_rdata_d = mem_rdata;
            data_dok_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset clears everything so all outputs read 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      streak_q     <= '0;
      owner_q      <= OWN_DATA;
      drop_q       <= 1'b0;
      we_q         <= 1'b0;
      wstrb_q      <= 4'b0000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
      inst_dok_q   <= 1'b0;
      data_dok_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      owner_q      <= owner_d;
      drop_q       <= drop_d;
      we_q         <= we_d;
      wstrb_q      <= wstrb_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_dok_q   <= inst_dok_d;
      data_dok_q   <= data_dok_d;
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign inst_data_ok = inst_dok_q;
  assign data_data_ok = data_dok_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;
  assign mem_req      = (state_q == S_REQ);
  assign mem_we       = we_q;
  assign mem_wstrb    = wstrb_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small memory responder that can run
// automatically (configurable addr_ok wait, one-cycle data_ok) or be driven
// by hand cycle by cycle.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_cancel;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_we;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  sram_arbiter #(.MAX_DATA_STREAK(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Pulse monitor, sampled on the falling edge.
  int   inst_dok_cnt = 0;
  int   data_dok_cnt = 0;
  int   both_cnt = 0;
  logic grant_log[$];

  initial begin
    forever begin
      @(negedge clk);
      if (inst_data_ok) inst_dok_cnt++;
      if (data_data_ok) data_dok_cnt++;
      if (inst_addr_ok) grant_log.push_back(1'b1);
      if (data_addr_ok) grant_log.push_back(1'b0);
      if ((inst_addr_ok && data_addr_ok) || (inst_data_ok && data_data_ok)) both_cnt++;
    end
  end

  // Memory responder.
  logic        man_mode = 1'b1;
  logic        man_aok = 1'b0;
  logic        man_dok = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  int          addr_delay = 0;
  logic [31:0] rsp_val = 32'h0;

  initial begin
    int  wait_cnt;
    bit  pending;
    wait_cnt    = 0;
    pending     = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
    forever begin
      @(posedge clk);
      #4;
      if (man_mode || reset) begin
        mem_addr_ok = man_mode ? man_aok : 1'b0;
        mem_data_ok = man_mode ? man_dok : 1'b0;
        mem_rdata   = man_mode ? man_rdata : 32'h0;
        pending     = 1'b0;
        wait_cnt    = 0;
      end else begin
        mem_addr_ok = 1'b0;
        mem_data_ok = pending;
        mem_rdata   = pending ? rsp_val : 32'h0;
        pending     = 1'b0;
        if (mem_req) begin
          if (wait_cnt >= addr_delay) begin
            mem_addr_ok = 1'b1;
            wait_cnt    = 0;
            pending     = 1'b1;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "bench timeout");
  end

  initial begin
    int   dcnt, icnt;
    logic exp_order [6];
    reset = 1'b1;
    inst_req = 1'b0; inst_cancel = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_we = 1'b0; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    exp_order = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    repeat (3) tick();
    reset = 1'b0;

    // Reset while a load sits in RESP.
    tick();
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h1c000040;
    #1 check_val("rst_pre_aok", data_addr_ok, 1);
    tick();
    data_req = 1'b0; man_aok = 1'b1;
    check_val("rst_pre_memreq", mem_req, 1);
    tick();
    man_aok = 1'b0;
    check_val("rst_pre_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("rst_busy", busy, 0);
    check_val("rst_ctrl", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                           mem_req, mem_we, mem_wstrb}, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    check_val("rst_rdata", data_rdata | inst_rdata, 0);
    dcnt = data_dok_cnt;
    man_dok = 1'b1; man_rdata = 32'ha5a5a5a5;
    tick();
    man_dok = 1'b0;
    tick(); tick();
    check_val("rst_late_dok", data_dok_cnt - dcnt, 0);
    check_val("rst_late_rdata", data_rdata, 0);

    // Single load, zero-wait memory.
    man_mode = 1'b0; addr_delay = 0; rsp_val = 32'hdeadbeef;
    tick();
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h1c000100;
    #1 check_val("ld_aok_t", data_addr_ok, 1);
    tick();
    data_req = 1'b0;
    check_val("ld_memreq_t1", mem_req, 1);
    check_val("ld_wstrb_t1", {mem_we, mem_wstrb}, 0);
    check_val("ld_addr_t1", mem_addr, 32'h1c000100);
    tick();
    check_val("ld_dok_t2", data_data_ok, 0);
    tick();
    check_val("ld_dok_t3", data_data_ok, 1);
    check_val("ld_rdata_t3", data_rdata, 32'hdeadbeef);
    check_val("ld_inst_rdata", inst_rdata, 0);
    check_val("ld_busy_t3", busy, 0);
    tick();
    check_val("ld_dok_t4", data_data_ok, 0);

    // Store with mem_addr_ok held off for three cycles.
    addr_delay = 3; rsp_val = 32'h0;
    tick();
    data_req = 1'b1; data_we = 1'b1; data_wstrb = 4'b0011;
    data_wdata = 32'h12345678; data_addr = 32'h1c000200;
    #1 check_val("st_aok", data_addr_ok, 1);
    dcnt = data_dok_cnt;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) begin
        data_req = 1'b0; data_we = 1'b0; data_wstrb = 4'hf;
        data_wdata = 32'h0; data_addr = 32'hffffffff;
      end
      check_val($sformatf("st_memreq_%0d", k), mem_req, 1);
      check_val($sformatf("st_addr_%0d", k), mem_addr, 32'h1c000200);
      check_val($sformatf("st_wdata_%0d", k), mem_wdata, 32'h12345678);
      check_val($sformatf("st_strb_%0d", k), {mem_we, mem_wstrb}, 5'b10011);
    end
    tick();
    check_val("st_memreq_drop", mem_req, 0);
    repeat (4) tick();
    check_val("st_dok_once", data_dok_cnt - dcnt, 1);

    // Both requesters held: data, data, inst, data, data, inst.
    addr_delay = 0; rsp_val = 32'h0badf00d;
    tick();
    inst_req = 1'b1; inst_addr = 32'h1c008000;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h1c000300;
    grant_log.delete();
    for (int c = 0; c < 40; c++) begin
      tick();
      if (grant_log.size() >= 6) break;
    end
    inst_req = 1'b0; data_req = 1'b0;
    repeat (4) tick();
    check_val("arb_grants", grant_log.size() >= 6, 1);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size())
        check_val($sformatf("arb_order_%0d", i), grant_log[i], exp_order[i]);
      else
        check_val($sformatf("arb_order_%0d", i), 32'hffffffff, exp_order[i]);
    end
    check_val("arb_inst_rdata", inst_rdata, 32'h0badf00d);

    // Fetch cancelled while in RESP; pending load goes next.
    man_mode = 1'b1;
    tick();
    inst_req = 1'b1; inst_addr = 32'h1c008040;
    #1 check_val("cxl_inst_aok", inst_addr_ok, 1);
    icnt = inst_dok_cnt;
    tick();
    inst_req = 1'b0; man_aok = 1'b1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h1c000400;
    #1 check_val("cxl_no_data_aok_busy", data_addr_ok, 0);
    tick();
    man_aok = 1'b0; inst_cancel = 1'b1;
    tick();
    inst_cancel = 1'b0; man_dok = 1'b1; man_rdata = 32'h5555aaaa;
    tick();
    man_dok = 1'b0;
    check_val("cxl_inst_dok", inst_data_ok, 0);
    #1 check_val("cxl_data_acc", data_addr_ok, 1);
    tick();
    data_req = 1'b0; man_aok = 1'b1;
    check_val("cxl_data_addr", mem_addr, 32'h1c000400);
    tick();
    man_aok = 1'b0; man_dok = 1'b1; man_rdata = 32'h00000077;
    tick();
    man_dok = 1'b0;
    check_val("cxl_data_dok", data_data_ok, 1);
    check_val("cxl_data_rdata", data_rdata, 32'h00000077);
    tick();
    check_val("cxl_inst_dok_cnt", inst_dok_cnt - icnt, 0);

    // inst_req with same-cycle cancel in IDLE is never accepted.
    tick();
    inst_req = 1'b1; inst_cancel = 1'b1;
    #1 check_val("cxlidle_aok0", inst_addr_ok, 0);
    tick();
    check_val("cxlidle_busy", busy, 0);
    #1 check_val("cxlidle_aok1", inst_addr_ok, 0);
    tick();
    inst_req = 1'b0; inst_cancel = 1'b0;
    tick();
    check_val("pulse_exclusive", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
